// File: rtl/quadrature_generator_if.sv
// Step-command channel for quadrature_generator: one command per valid/ready handshake.
interface quadrature_generator_if #(
  parameter int unsigned w_pos    = 16,
  parameter int unsigned w_period = 16
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_dir;
  logic [w_pos-1:0]    cmd_steps;
  logic [w_period-1:0] cmd_period;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/quadrature_generator.sv
// KY-040 style quadrature emitter: each accepted command emits cmd_steps Gray-code
// transitions on a/b, spaced cmd_period clocks apart, and tracks a signed position.
module quadrature_generator #(
  parameter int unsigned w_pos    = 16,
  parameter int unsigned w_period = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  quadrature_generator_if.slave cmd,
  input  logic                 abort,
  output logic                 a,
  output logic                 b,
  output logic                 busy,
  output logic                 done,
  output logic [w_pos-1:0]     position
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_dir;
  logic [w_pos-1:0]    r_remaining;
  logic [w_period-1:0] r_reload;
  logic [w_period-1:0] r_count;
  logic                r_a;
  logic                r_b;
  logic [w_pos-1:0]    r_pos;
  logic                w_accept;
  logic                w_step;
  logic [w_period-1:0] w_period_m1;

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_step        = 1'b0;
    cmd.cmd_ready = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    // A zero period behaves as one, so its reload value is also zero.
    w_period_m1   = (cmd.cmd_period == '0) ? '0 : cmd.cmd_period - w_period'(1);
    case (r_state)
      IDLE: begin
        cmd.cmd_ready = 1'b1;
        if (cmd.cmd_valid) begin
          w_accept = 1'b1;
          w_next   = (cmd.cmd_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          w_next = DONE;
        end else if (r_count == '0) begin
          w_step = 1'b1;
          if (r_remaining == w_pos'(1)) w_next = DONE;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_dir       <= 1'b0;
      r_remaining <= '0;
      r_reload    <= '0;
      r_count     <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_pos       <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_dir       <= cmd.cmd_dir;
        r_remaining <= cmd.cmd_steps;
        r_reload    <= w_period_m1;
        r_count     <= w_period_m1;
      end else if (r_state == RUN && !abort) begin
        if (w_step) begin
          r_count     <= r_reload;
          r_remaining <= r_remaining - w_pos'(1);
          // CW walks 00->10->11->01, CCW the reverse; exactly one bit flips.
          if (r_dir) begin
            r_a   <= ~r_b;
            r_b   <= r_a;
            r_pos <= r_pos + w_pos'(1);
          end else begin
            r_a   <= r_b;
            r_b   <= ~r_a;
            r_pos <= r_pos - w_pos'(1);
          end
        end else begin
          r_count <= r_count - w_period'(1);
        end
      end
    end
  end

  assign a        = r_a;
  assign b        = r_b;
  assign position = r_pos;
endmodule
